// File: rtl/faultdetector_dl_report_unit_if.sv
// ----------------------------------------------------------------------------
// faultdetector_dl_report_unit_if
//   Groups the signals between the deadlock report unit and the ring of
//   per-process detect units, plus the clear input and the ID report stream.
//
//   Ring / control side -> report unit:
//     dl_detect_vec  [PROC_NUM]  bit i = dl_detect_out of detect unit i
//     token_vec      [PROC_NUM]  bit i = |token_in_vec of unit i (status only)
//     dl_clear                   1-cycle pulse, re-arms after a finished trace
//   Report unit -> ring / consumers:
//     dl_detect_in               broadcast to every detect unit
//     origin_vec     [PROC_NUM]  one-hot origin pulse to the chosen unit
//     token_clear                1-cycle pulse when a trace closes
//     report_valid               report_proc_id valid this cycle
//     report_proc_id [IDW]       ID of a process on the deadlock cycle
//     report_last                final report of the trace
//     dl_status      [2]         00 none, 01 confirming, 10 complete, 11 timeout
//     dl_cycle_len   [IDW+1]     IDs reported in the current/last trace
//
//   Modports: master = the report unit, slave = the ring / consumer side.
// ----------------------------------------------------------------------------
interface faultdetector_dl_report_unit_if #(
    parameter int PROC_NUM = 4,
    parameter int IDW      = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
);
    logic [PROC_NUM-1:0] dl_detect_vec;
    logic [PROC_NUM-1:0] token_vec;
    logic                dl_clear;
    logic                dl_detect_in;
    logic [PROC_NUM-1:0] origin_vec;
    logic                token_clear;
    logic                report_valid;
    logic [IDW-1:0]      report_proc_id;
    logic                report_last;
    logic [1:0]          dl_status;
    logic [IDW:0]        dl_cycle_len;

    modport master (
        input  dl_detect_vec, token_vec, dl_clear,
        output dl_detect_in, origin_vec, token_clear, report_valid,
               report_proc_id, report_last, dl_status, dl_cycle_len
    );

    modport slave (
        output dl_detect_vec, token_vec, dl_clear,
        input  dl_detect_in, origin_vec, token_clear, report_valid,
               report_proc_id, report_last, dl_status, dl_cycle_len
    );
endinterface

// File: rtl/faultdetector_dl_report_unit.sv
// ----------------------------------------------------------------------------
// faultdetector_dl_report_unit
//   Central end of the per-process deadlock-detection ring. Watches the
//   dl_detect outputs of all detect units, confirms a deadlock after
//   CONFIRM_CYCLES consecutive cycles of detection, injects the origin into
//   the lowest detecting unit, then streams the IDs of the processes that
//   join the trace (one per cycle, lowest ID first) until the origin sees the
//   trace come back (complete) or no new process shows up for TRACE_TIMEOUT
//   cycles (incomplete). A dl_clear pulse in DONE re-arms the unit.
//
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-low
//     bus    faultdetector_dl_report_unit_if.master (see interface header)
//
//   All outputs are registered. dl_status reads 01 from the first detection
//   until the trace closes, then 10/11 until dl_clear.
// ----------------------------------------------------------------------------
module faultdetector_dl_report_unit #(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 8,
    parameter int TRACE_TIMEOUT  = 256,
    parameter int IDW            = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
    input logic                          clock,
    input logic                          reset,
    faultdetector_dl_report_unit_if.master bus
);

    localparam int CW = $clog2(CONFIRM_CYCLES + 1);
    localparam int TW = $clog2(TRACE_TIMEOUT + 1);
    localparam int LW = IDW + 1;

    localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(TRACE_TIMEOUT);
    localparam logic [LW-1:0] LEN_MAX   = LW'(PROC_NUM);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_CONFIRM = 2'b01;
    localparam logic [1:0] ST_DONE_OK = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIRM,
        S_ORIGIN,
        S_TRACE,
        S_DONE
    } state_t;

    // Lowest set bit of v as an index (0 when v is empty).
    function automatic logic [IDW-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
        logic [IDW-1:0] r;
        r = '0;
        for (int unsigned i = PROC_NUM; i > 0; i--) begin
            if (v[i-1]) r = IDW'(i - 1);
        end
        return r;
    endfunction

    function automatic logic [PROC_NUM-1:0] onehot(input logic [IDW-1:0] idx);
        logic [PROC_NUM-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < PROC_NUM; i++) begin
            if (idx == IDW'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Control state
    state_t              state_q,      state_d;
    logic [CW-1:0]       conf_cnt_q,   conf_cnt_d;
    logic [TW-1:0]       idle_cnt_q,   idle_cnt_d;
    logic [PROC_NUM-1:0] visited_q,    visited_d;
    logic [PROC_NUM-1:0] pending_q,    pending_d;
    logic [IDW-1:0]      origin_idx_q, origin_idx_d;
    logic                close_seen_q, close_seen_d;

    // Registered outputs
    logic                dl_detect_in_q,   dl_detect_in_d;
    logic [PROC_NUM-1:0] origin_vec_q,     origin_vec_d;
    logic                token_clear_q,    token_clear_d;
    logic                report_valid_q,   report_valid_d;
    logic [IDW-1:0]      report_proc_id_q, report_proc_id_d;
    logic                report_last_q,    report_last_d;
    logic [1:0]          dl_status_q,      dl_status_d;
    logic [LW-1:0]       dl_cycle_len_q,   dl_cycle_len_d;

    // Combinational helpers
    logic                any_det;
    logic                go_origin;
    logic [CW-1:0]       conf_inc;
    logic [TW-1:0]       idle_inc;
    logic [PROC_NUM-1:0] origin_bit;
    logic [PROC_NUM-1:0] pend_all;
    logic [IDW-1:0]      rep_idx;
    logic [PROC_NUM-1:0] rep_bit;
    logic [PROC_NUM-1:0] pend_after;
    logic                have_rep;
    logic                close_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            conf_cnt_q       <= '0;
            idle_cnt_q       <= '0;
            visited_q        <= '0;
            pending_q        <= '0;
            origin_idx_q     <= '0;
            close_seen_q     <= 1'b0;
            dl_detect_in_q   <= 1'b0;
            origin_vec_q     <= '0;
            token_clear_q    <= 1'b0;
            report_valid_q   <= 1'b0;
            report_proc_id_q <= '0;
            report_last_q    <= 1'b0;
            dl_status_q      <= ST_NONE;
            dl_cycle_len_q   <= '0;
        end else begin
            state_q          <= state_d;
            conf_cnt_q       <= conf_cnt_d;
            idle_cnt_q       <= idle_cnt_d;
            visited_q        <= visited_d;
            pending_q        <= pending_d;
            origin_idx_q     <= origin_idx_d;
            close_seen_q     <= close_seen_d;
            dl_detect_in_q   <= dl_detect_in_d;
            origin_vec_q     <= origin_vec_d;
            token_clear_q    <= token_clear_d;
            report_valid_q   <= report_valid_d;
            report_proc_id_q <= report_proc_id_d;
            report_last_q    <= report_last_d;
            dl_status_q      <= dl_status_d;
            dl_cycle_len_q   <= dl_cycle_len_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        conf_cnt_d       = conf_cnt_q;
        idle_cnt_d       = idle_cnt_q;
        visited_d        = visited_q;
        pending_d        = pending_q;
        origin_idx_d     = origin_idx_q;
        close_seen_d     = close_seen_q;
        dl_detect_in_d   = dl_detect_in_q;
        origin_vec_d     = '0;
        token_clear_d    = 1'b0;
        report_valid_d   = 1'b0;
        report_proc_id_d = report_proc_id_q;
        report_last_d    = 1'b0;
        dl_status_d      = dl_status_q;
        dl_cycle_len_d   = dl_cycle_len_q;
        go_origin        = 1'b0;

        any_det    = |bus.dl_detect_vec;
        conf_inc   = conf_cnt_q + 1'b1;
        idle_inc   = idle_cnt_q + 1'b1;
        origin_bit = onehot(origin_idx_q);
        // New arrivals: detecting, not yet reported, and not the origin itself.
        pend_all   = pending_q | (bus.dl_detect_vec & ~visited_q & ~origin_bit);
        have_rep   = |pend_all;
        rep_idx    = lowest_idx(pend_all);
        rep_bit    = onehot(rep_idx);
        pend_after = pend_all & ~rep_bit;
        // Once the origin has seen the trace return, closing is latched so the
        // remaining pending IDs drain before token_clear.
        close_req  = close_seen_q | (|(bus.dl_detect_vec & origin_bit));

        case (state_q)
            S_IDLE: begin
                conf_cnt_d = '0;
                if (any_det) begin
                    if (CONFIRM_CYCLES == 1) begin
                        go_origin = 1'b1;
                    end else begin
                        conf_cnt_d  = CW'(1);
                        dl_status_d = ST_CONFIRM;
                        state_d     = S_CONFIRM;
                    end
                end
            end

            S_CONFIRM: begin
                if (!any_det) begin
                    conf_cnt_d  = '0;
                    dl_status_d = ST_NONE;
                    state_d     = S_IDLE;
                end else begin
                    conf_cnt_d = conf_inc;
                    if (conf_inc == CONF_LAST) go_origin = 1'b1;
                end
            end

            S_ORIGIN: begin
                state_d = S_TRACE;
            end

            S_TRACE: begin
                close_seen_d = close_req;
                if (have_rep) begin
                    report_valid_d   = 1'b1;
                    report_proc_id_d = rep_idx;
                    pending_d        = pend_after;
                    visited_d        = visited_q | rep_bit;
                    idle_cnt_d       = '0;
                    if (dl_cycle_len_q < LEN_MAX) dl_cycle_len_d = dl_cycle_len_q + 1'b1;
                end else begin
                    pending_d  = '0;
                    idle_cnt_d = idle_inc;
                end

                if (close_req && (pend_after == '0)) begin
                    token_clear_d = 1'b1;
                    report_last_d = have_rep;
                    dl_status_d   = ST_DONE_OK;
                    state_d       = S_DONE;
                end else if (!have_rep && (idle_inc == TO_LAST)) begin
                    token_clear_d = 1'b1;
                    dl_status_d   = ST_TIMEOUT;
                    state_d       = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.dl_clear) begin
                    dl_detect_in_d = 1'b0;
                    dl_status_d    = ST_NONE;
                    pending_d      = '0;
                    visited_d      = '0;
                    close_seen_d   = 1'b0;
                    idle_cnt_d     = '0;
                    state_d        = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_origin) begin
            origin_idx_d     = lowest_idx(bus.dl_detect_vec);
            origin_vec_d     = onehot(origin_idx_d);
            dl_detect_in_d   = 1'b1;
            report_valid_d   = 1'b1;
            report_proc_id_d = origin_idx_d;
            visited_d        = onehot(origin_idx_d);
            pending_d        = '0;
            close_seen_d     = 1'b0;
            dl_cycle_len_d   = LW'(1);
            idle_cnt_d       = '0;
            conf_cnt_d       = '0;
            dl_status_d      = ST_CONFIRM;
            state_d          = S_ORIGIN;
        end
    end

    assign bus.dl_detect_in   = dl_detect_in_q;
    assign bus.origin_vec     = origin_vec_q;
    assign bus.token_clear    = token_clear_q;
    assign bus.report_valid   = report_valid_q;
    assign bus.report_proc_id = report_proc_id_q;
    assign bus.report_last    = report_last_q;
    assign bus.dl_status      = dl_status_q;
    assign bus.dl_cycle_len   = dl_cycle_len_q;

endmodule
